mc_main_control: RTL

Main control state machine for the multi-cycle MIPS datapath. It sequences the shared ALU, the instruction register, unified memory, the register file and the immediate extender across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It takes the opcode from the instruction register and a memory-ready handshake, and drives every datapath mux select and write enable. It also selects sign- versus zero-extension of the 16-bit immediate for each instruction.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/mc_ctrl_out_decode.sv | 112 +++++++++++
 rtl/mc_main_control.sv | 97 +++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: state
// encoding, opcodes, ALU-op codes, mux selects and the control bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_IMM_WB   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12
    } state_t;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation requests to the ALU control block
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    // ALU B-input select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Every datapath control the FSM drives, bundled for the decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    // True for every opcode this control unit knows how to sequence
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_ORI, OP_J: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational output decoder for the main control FSM. Outputs follow
// the current state; only FETCH looks at mem_ready_i (to gate the PC and
// IR loads) and only DECODE/BRANCH/EXEC_I look at the opcode.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op_i,
    input  logic        mem_ready_i,
    output ctrl_t       ctrl
);

    // Decode the control bundle from the current state
    always_comb begin
        ctrl = '0;
        case (state)
            ST_IDLE: begin
                ctrl = '0;
            end
            ST_FETCH: begin
                // PC+4 computed on the ALU while the instruction is read;
                // both loads wait for memory to complete the read.
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_SRC_ALU;
                ctrl.pc_write  = mem_ready_i;
                ctrl.ir_write  = mem_ready_i;
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_zero  = 1'b0;
                ctrl.illegal   = ~is_legal_op(op_i);
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_zero  = 1'b0;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                case (op_i)
                    OP_SLTI: begin
                        ctrl.alu_op   = ALU_SLT;
                        ctrl.ext_zero = 1'b0;
                    end
                    OP_ORI: begin
                        // ALU control maps funct-decoded + ori to OR; the
                        // logical immediate must not be sign-extended.
                        ctrl.alu_op   = ALU_FUNCT;
                        ctrl.ext_zero = 1'b1;
                    end
                    default: begin
                        ctrl.alu_op   = ALU_ADD;
                        ctrl.ext_zero = 1'b0;
                    end
                endcase
            end
            ST_IMM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
                ctrl.branch_ne     = (op_i == OP_BNE);
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Holds the state
// register and next-state logic; all datapath controls come from the
// output decoder driven by the registered state.
module mc_main_control
    import mc_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        pc_write_cond_o,
    output logic        branch_ne_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        mem_to_reg_o,
    output logic        reg_dst_o,
    output logic        reg_write_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        ext_zero_o,
    output logic [1:0]  pc_source_o,
    output logic        illegal_o
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing; memory states hold until mem_ready_i
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     state_next = ST_FETCH;
            ST_FETCH:    state_next = mem_ready_i ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op_i)
                    OP_RTYPE:                 state_next = ST_EXEC_R;
                    OP_LW, OP_SW:             state_next = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:           state_next = ST_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ORI: state_next = ST_EXEC_I;
                    OP_J:                     state_next = ST_JUMP;
                    default:                  state_next = ST_FETCH;
                endcase
            end
            // Only lw and sw reach address calculation
            ST_MEM_ADDR: state_next = (op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_next = mem_ready_i ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   state_next = ST_FETCH;
            ST_MEM_WR:   state_next = mem_ready_i ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   state_next = ST_ALU_WB;
            ST_ALU_WB:   state_next = ST_FETCH;
            ST_EXEC_I:   state_next = ST_IMM_WB;
            ST_IMM_WB:   state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            default:     state_next = ST_IDLE;
        endcase
    end

    mc_ctrl_out_decode u_out_decode (
        .state       (state_reg),
        .op_i        (op_i),
        .mem_ready_i (mem_ready_i),
        .ctrl        (ctrl)
    );

    assign pc_write_o      = ctrl.pc_write;
    assign pc_write_cond_o = ctrl.pc_write_cond;
    assign branch_ne_o     = ctrl.branch_ne;
    assign iord_o          = ctrl.iord;
    assign mem_read_o      = ctrl.mem_read;
    assign mem_write_o     = ctrl.mem_write;
    assign ir_write_o      = ctrl.ir_write;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign reg_dst_o       = ctrl.reg_dst;
    assign reg_write_o     = ctrl.reg_write;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign alu_src_b_o     = ctrl.alu_src_b;
    assign alu_op_o        = ctrl.alu_op;
    assign ext_zero_o      = ctrl.ext_zero;
    assign pc_source_o     = ctrl.pc_source;
    assign illegal_o       = ctrl.illegal;

endmodule
